tmvp_job_ctrl: RTL and testbench

Job sequencer and operand server for the MainMultiplier TMVP datapath. Loads one job's Toeplitz row, column and vector operands from a single input stream into local banks, then pulses the multiplier's `start`. It answers every multiplier address request with 1-cycle read latency, forwards the N results and signals completion. It sits between the host/DMA stream and MainMultiplier and replaces bench-side operand memories.

---
 rtl/tmvp_job_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_tmvp_job_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmvp_job_ctrl.sv
// -----------------------------------------------------------------------------
// tmvp_job_ctrl
// Job sequencer and operand server for the MainMultiplier TMVP datapath.
// One job:
//   1. Stream 3N operand beats into the row, col and vec banks, in that order.
//   2. Pulse mm_start for one cycle.
//   3. Serve every multiplier read request with 1-cycle latency.
//   4. Forward the N results and pulse done.
//
// Ports
//   clk, reset            : clock (rising edge), asynchronous active-low reset
//   cmd_start             : begin a job, sampled only while idle
//   s_axis_*              : operand load stream (tready high only while loading)
//   mm_start              : one-cycle start pulse to the multiplier
//   mm_address_*          : multiplier read requests (row/col and vec)
//   mm_data_*             : read responses, one cycle after the request
//   mm_tdata/mm_tvalid    : multiplier results
//   m_axis_tdata/tvalid   : forwarded results (no backpressure)
//   busy, done            : job status; done pulses once per finished job
//   run_cycles            : cycles from mm_start to the last result
// -----------------------------------------------------------------------------
module tmvp_job_ctrl #(
  parameter int N          = 864,
  parameter int DATA_WIDTH = 4,
  parameter int AW         = $clog2(N),
  parameter int OUT_WIDTH  = 2*DATA_WIDTH+$clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  mm_start,
  input  logic [AW-1:0]         mm_address_1,
  input  logic [AW-1:0]         mm_address_2,
  input  logic                  mm_address_1_isRow,
  input  logic                  mm_address_2_isRow,
  input  logic                  mm_address_valid,
  input  logic [AW-1:0]         mm_address_vec_1,
  input  logic [AW-1:0]         mm_address_vec_2,
  input  logic                  mm_address_vec_valid,
  output logic [DATA_WIDTH-1:0] mm_data_row_data_1,
  output logic [DATA_WIDTH-1:0] mm_data_row_data_2,
  output logic                  mm_data_row_valid,
  output logic [DATA_WIDTH-1:0] mm_data_vec_data_1,
  output logic [DATA_WIDTH-1:0] mm_data_vec_data_2,
  output logic                  mm_data_vec_valid,
  input  logic [OUT_WIDTH-1:0]  mm_tdata,
  input  logic                  mm_tvalid,
  output logic [OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           run_cycles
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int BANK_ROW = 0;
  localparam int BANK_COL = 1;
  localparam int BANK_VEC = 2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N-1);
  // One extra bit so the range test also works when N is a power of two.
  localparam logic [AW:0]   N_EXT     = (AW+1)'(N);

  state_t         state_reg;
  logic [1:0]     load_bank_reg;   // which bank the next beat lands in
  logic [AW-1:0]  load_addr_reg;   // offset inside that bank
  logic [AW-1:0]  result_cnt_reg;

  logic           rd_en;
  assign rd_en = (state_reg == RUN);

  // ---------------------------------------------------------------------------
  // Operand banks: one write port and two registered read ports each.
  // The row and col banks are both read at the row/col request addresses and
  // the isRow choice is applied after the read register. This keeps each bank
  // a plain registered-read memory.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [N];
      logic [DATA_WIDTH-1:0] rd_a_reg;
      logic [DATA_WIDTH-1:0] rd_b_reg;
      logic [AW-1:0]         raddr_a;
      logic [AW-1:0]         raddr_b;
      logic                  we;

      assign raddr_a = (gi == BANK_VEC) ? mm_address_vec_1 : mm_address_1;
      assign raddr_b = (gi == BANK_VEC) ? mm_address_vec_2 : mm_address_2;
      assign we      = (state_reg == LOAD) && s_axis_tvalid &&
                       (load_bank_reg == 2'(gi));

      // No reset: bank contents survive a reset, and the read registers are
      // masked by the blank flags below until the first RUN cycle.
      always_ff @(posedge clk) begin
        if (we) begin
          mem[load_addr_reg] <= s_axis_tdata;
        end
        if (rd_en) begin
          rd_a_reg <= mem[raddr_a];
          rd_b_reg <= mem[raddr_b];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read-port side information, captured in the same cycle as the bank read.
  // A blank flag forces that port's data to zero: it is set for out-of-range
  // addresses and comes out of reset set, so the outputs start at zero.
  // ---------------------------------------------------------------------------
  logic row_sel_1_reg, row_sel_2_reg;
  logic row_blank_1_reg, row_blank_2_reg;
  logic vec_blank_1_reg, vec_blank_2_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_sel_1_reg     <= 1'b0;
      row_sel_2_reg     <= 1'b0;
      row_blank_1_reg   <= 1'b1;
      row_blank_2_reg   <= 1'b1;
      vec_blank_1_reg   <= 1'b1;
      vec_blank_2_reg   <= 1'b1;
      mm_data_row_valid <= 1'b0;
      mm_data_vec_valid <= 1'b0;
    end else begin
      if (rd_en) begin
        row_sel_1_reg   <= mm_address_1_isRow;
        row_sel_2_reg   <= mm_address_2_isRow;
        row_blank_1_reg <= ({1'b0, mm_address_1} >= N_EXT);
        row_blank_2_reg <= ({1'b0, mm_address_2} >= N_EXT);
        vec_blank_1_reg <= ({1'b0, mm_address_vec_1} >= N_EXT);
        vec_blank_2_reg <= ({1'b0, mm_address_vec_2} >= N_EXT);
      end
      mm_data_row_valid <= rd_en && mm_address_valid;
      mm_data_vec_valid <= rd_en && mm_address_vec_valid;
    end
  end

  assign mm_data_row_data_1 = row_blank_1_reg ? '0 :
                              (row_sel_1_reg ? g_bank[BANK_ROW].rd_a_reg
                                             : g_bank[BANK_COL].rd_a_reg);
  assign mm_data_row_data_2 = row_blank_2_reg ? '0 :
                              (row_sel_2_reg ? g_bank[BANK_ROW].rd_b_reg
                                             : g_bank[BANK_COL].rd_b_reg);
  assign mm_data_vec_data_1 = vec_blank_1_reg ? '0 : g_bank[BANK_VEC].rd_a_reg;
  assign mm_data_vec_data_2 = vec_blank_2_reg ? '0 : g_bank[BANK_VEC].rd_b_reg;

  // ---------------------------------------------------------------------------
  // Result forwarding: one register stage, open only during RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      m_axis_tvalid <= rd_en && mm_tvalid;
      if (rd_en) begin
        m_axis_tdata <= mm_tdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Job FSM with registered status outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      load_bank_reg  <= 2'd0;
      load_addr_reg  <= '0;
      result_cnt_reg <= '0;
      run_cycles     <= 32'd0;
      s_axis_tready  <= 1'b0;
      mm_start       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_start) begin
            state_reg     <= LOAD;
            load_bank_reg <= 2'd0;
            load_addr_reg <= '0;
            s_axis_tready <= 1'b1;
            busy          <= 1'b1;
          end
        end
        LOAD: begin
          // tready is high throughout LOAD, so tvalid alone is the handshake.
          if (s_axis_tvalid) begin
            if (load_addr_reg == LAST_ADDR) begin
              load_addr_reg <= '0;
              if (load_bank_reg == 2'(BANK_VEC)) begin
                state_reg     <= START;
                s_axis_tready <= 1'b0;
                mm_start      <= 1'b1;
              end else begin
                load_bank_reg <= load_bank_reg + 2'd1;
              end
            end else begin
              load_addr_reg <= load_addr_reg + AW'(1);
            end
          end
        end
        START: begin
          result_cnt_reg <= '0;
          run_cycles     <= 32'd0;
          state_reg      <= RUN;
        end
        RUN: begin
          run_cycles <= run_cycles + 32'd1;
          if (mm_tvalid) begin
            result_cnt_reg <= result_cnt_reg + AW'(1);
            if (result_cnt_reg == LAST_ADDR) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg     <= IDLE;
          s_axis_tready <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmvp_job_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tmvp_job_ctrl
// Directed bench for tmvp_job_ctrl. The bench plays the multiplier: it issues
// read requests and returns N results. Inputs are driven on the falling edge
// and outputs are sampled on the falling edge, mid-cycle.
// -----------------------------------------------------------------------------
module tb_tmvp_job_ctrl;

  localparam int N  = 864;
  localparam int DW = 4;
  localparam int AW = $clog2(N);
  localparam int OW = 2*DW+$clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_start = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          mm_start;
  logic [AW-1:0] mm_address_1 = '0;
  logic [AW-1:0] mm_address_2 = '0;
  logic          mm_address_1_isRow = 1'b0;
  logic          mm_address_2_isRow = 1'b0;
  logic          mm_address_valid = 1'b0;
  logic [AW-1:0] mm_address_vec_1 = '0;
  logic [AW-1:0] mm_address_vec_2 = '0;
  logic          mm_address_vec_valid = 1'b0;
  logic [DW-1:0] mm_data_row_data_1, mm_data_row_data_2;
  logic          mm_data_row_valid;
  logic [DW-1:0] mm_data_vec_data_1, mm_data_vec_data_2;
  logic          mm_data_vec_valid;
  logic [OW-1:0] mm_tdata = '0;
  logic          mm_tvalid = 1'b0;
  logic [OW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          busy;
  logic          done;
  logic [31:0]   run_cycles;

  tmvp_job_ctrl #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .cmd_start            (cmd_start),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .mm_start             (mm_start),
    .mm_address_1         (mm_address_1),
    .mm_address_2         (mm_address_2),
    .mm_address_1_isRow   (mm_address_1_isRow),
    .mm_address_2_isRow   (mm_address_2_isRow),
    .mm_address_valid     (mm_address_valid),
    .mm_address_vec_1     (mm_address_vec_1),
    .mm_address_vec_2     (mm_address_vec_2),
    .mm_address_vec_valid (mm_address_vec_valid),
    .mm_data_row_data_1   (mm_data_row_data_1),
    .mm_data_row_data_2   (mm_data_row_data_2),
    .mm_data_row_valid    (mm_data_row_valid),
    .mm_data_vec_data_1   (mm_data_vec_data_1),
    .mm_data_vec_data_2   (mm_data_vec_data_2),
    .mm_data_vec_valid    (mm_data_vec_valid),
    .mm_tdata             (mm_tdata),
    .mm_tvalid            (mm_tvalid),
    .m_axis_tdata         (m_axis_tdata),
    .m_axis_tvalid        (m_axis_tvalid),
    .busy                 (busy),
    .done                 (done),
    .run_cycles           (run_cycles)
  );

  always #5 clk = ~clk;

  // Rising-edge count, read only on falling edges.
  int cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Load stream pattern: row[i]=i%16, col[i]=(i+3)%16, vec[i]=15-i%16.
  function automatic logic [DW-1:0] beat_val(input int b);
    int v;
    if (b < N)        v = b % 16;
    else if (b < 2*N) v = (b - N + 3) % 16;
    else              v = 15 - ((b - 2*N) % 16);
    return DW'(v);
  endfunction

  // Streams beats with random gaps until nbeats are accepted (or the guard
  // expires). Also raises a stray cmd_start around beat 100.
  task automatic load_beats(input int nbeats, output int accepted, output int start_seen);
    int guard;
    guard      = 0;
    accepted   = 0;
    start_seen = 0;
    while (accepted < nbeats && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (mm_start) start_seen++;
      cmd_start     = (accepted == 100);
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = beat_val(accepted);
      if (s_axis_tvalid && s_axis_tready) accepted++;
    end
    cmd_start = 1'b0;
  endtask

  int acc, sseen, c_s, c_l, nres, guard;
  logic          prev_v;
  logic [OW-1:0] prev_d;
  logic          v;

  initial begin
    // ---------------- reset / idle ----------------
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tready",   32'(s_axis_tready), 32'd0);
    check("rst_mm_start", 32'(mm_start), 32'd0);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tdata",  32'(m_axis_tdata), 32'd0);
    check("rst_run_cyc",  run_cycles, 32'd0);
    check("rst_row_data", {mm_data_row_data_1, mm_data_row_data_2}, 32'd0);
    check("rst_vec_data", {mm_data_vec_data_1, mm_data_vec_data_2}, 32'd0);
    check("rst_valids",   {mm_data_row_valid, mm_data_vec_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    // stray result and read request while idle
    mm_tvalid        = 1'b1;
    mm_tdata         = OW'(123);
    mm_address_valid = 1'b1;
    @(negedge clk);
    check("idle_stray_result", 32'(m_axis_tvalid), 32'd0);
    check("idle_read_valid",   32'(mm_data_row_valid), 32'd0);
    check("idle_tready",       32'(s_axis_tready), 32'd0);
    mm_tvalid        = 1'b0;
    mm_address_valid = 1'b0;
    $display("phase reset/idle: %0d compared", n_cmp);

    // ---------------- load ----------------
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check("start_tready", 32'(s_axis_tready), 32'd1);
    check("start_busy",   32'(busy), 32'd1);
    load_beats(3*N, acc, sseen);
    check("load_accepted",    acc, 32'(3*N));
    check("load_early_start", sseen, 32'd0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    c_s = cyc;
    check("start_pulse",      32'(mm_start), 32'd1);
    check("load_tready_drop", 32'(s_axis_tready), 32'd0);
    $display("phase load: %0d beats accepted, mm_start at edge %0d", acc, c_s);

    // ---------------- read serving ----------------
    @(negedge clk);
    check("start_pulse_end", 32'(mm_start), 32'd0);
    mm_address_1 = 10'd5;   mm_address_1_isRow = 1'b1;
    mm_address_2 = 10'd5;   mm_address_2_isRow = 1'b0;
    mm_address_valid = 1'b1;
    mm_address_vec_1 = 10'd0;
    mm_address_vec_2 = 10'd863;
    mm_address_vec_valid = 1'b1;
    cmd_start = 1'b1;                       // ignored during RUN
    @(negedge clk);
    cmd_start = 1'b0;
    check("rd_row_5",    32'(mm_data_row_data_1), 32'd5);
    check("rd_col_5",    32'(mm_data_row_data_2), 32'd8);
    check("rd_vec_0",    32'(mm_data_vec_data_1), 32'd15);
    check("rd_vec_863",  32'(mm_data_vec_data_2), 32'd0);
    check("rd_row_valid", 32'(mm_data_row_valid), 32'd1);
    check("rd_vec_valid", 32'(mm_data_vec_valid), 32'd1);
    mm_address_1 = 10'd900; mm_address_1_isRow = 1'b1;
    mm_address_2 = 10'd7;   mm_address_2_isRow = 1'b1;
    mm_address_vec_1 = 10'd900;
    mm_address_vec_2 = 10'd16;
    @(negedge clk);
    check("rd_row_900",  32'(mm_data_row_data_1), 32'd0);
    check("rd_row_7",    32'(mm_data_row_data_2), 32'd7);
    check("rd_vec_900",  32'(mm_data_vec_data_1), 32'd0);
    check("rd_vec_16",   32'(mm_data_vec_data_2), 32'd15);
    mm_address_1 = 10'd863; mm_address_1_isRow = 1'b0;   // col[863]=(866)%16=2
    mm_address_valid = 1'b0;
    mm_address_vec_valid = 1'b0;
    @(negedge clk);
    check("rd_col_863",     32'(mm_data_row_data_1), 32'd2);
    check("rd_row_valid_0", 32'(mm_data_row_valid), 32'd0);
    check("rd_vec_valid_0", 32'(mm_data_vec_valid), 32'd0);
    check("run_busy",       32'(busy), 32'd1);
    check("run_tready",     32'(s_axis_tready), 32'd0);
    $display("phase read: %0d compared", n_cmp);

    // ---------------- results ----------------
    prev_v = 1'b0;
    prev_d = '0;
    nres   = 0;
    c_l    = 0;
    guard  = 0;
    while (nres < N && guard < 10000) begin
      @(negedge clk);
      guard++;
      check("fwd_tvalid", 32'(m_axis_tvalid), 32'(prev_v));
      if (prev_v) check("fwd_tdata", 32'(m_axis_tdata), 32'(prev_d));
      check("run_no_done", 32'(done), 32'd0);
      v = ($urandom_range(0, 4) != 0);
      mm_tvalid = v;
      mm_tdata  = OW'(nres * 37 + 11);
      prev_v = v;
      prev_d = mm_tdata;
      if (v) begin
        if (nres == N - 1) c_l = cyc;
        nres++;
      end
    end
    check("results_sent", nres, 32'(N));
    @(negedge clk);
    mm_tvalid = 1'b0;
    check("last_fwd_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("last_fwd_tdata",  32'(m_axis_tdata), 32'(prev_d));
    check("done_pulse",      32'(done), 32'd1);
    check("done_busy",       32'(busy), 32'd1);
    check("run_cycles",      run_cycles, 32'(c_l - c_s));
    @(negedge clk);
    check("done_end",        32'(done), 32'd0);
    check("busy_fall",       32'(busy), 32'd0);
    check("run_cycles_hold", run_cycles, 32'(c_l - c_s));
    check("done_count",      done_cnt, 32'd1);
    // stray result after the job
    mm_tvalid = 1'b1;
    @(negedge clk);
    mm_tvalid = 1'b0;
    check("post_stray_result", 32'(m_axis_tvalid), 32'd0);
    check("post_done_count",   done_cnt, 32'd1);
    $display("phase results: %0d results, run_cycles %0d", nres, run_cycles);

    // ---------------- reset mid-job ----------------
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    load_beats(1000, acc, sseen);
    check("partial_accepted", acc, 32'd1000);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_busy",   32'(busy), 32'd0);
    check("midrst_tready", 32'(s_axis_tready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_idle_tready", 32'(s_axis_tready), 32'd0);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check("reload_tready", 32'(s_axis_tready), 32'd1);
    load_beats(3*N, acc, sseen);
    check("reload_accepted",    acc, 32'(3*N));
    check("reload_early_start", sseen, 32'd0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    check("reload_start_pulse", 32'(mm_start), 32'd1);
    check("reload_tready_drop", 32'(s_axis_tready), 32'd0);
    $display("phase reset mid-job: reload accepted %0d beats", acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
